// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 raster timing from the 25 MHz pixel clock.
// Drives pixel coordinates and a per-frame game tick to the colour source.
// Blanks the returned colour and aligns it with the delayed hsync/vsync.
// The colour source's returned pixel is registered here, and that register
// is the last stage of the active delay line. The syncs use a full
// PIPE_DELAY-stage shift line, so a pixel's blanking decision reaches the
// pins on the same clock as the sync for the same count.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int FRAME_DIV  = 6,   // 1..255
    parameter int PIPE_DELAY = 1    // 1..4
) (
    input  logic       vga_clock,
    input  logic       reset,
    input  logic [3:0] r_in,
    input  logic [3:0] g_in,
    input  logic [3:0] b_in,
    output logic [9:0] screenX,
    output logic [8:0] screenY,
    output logic       refresh,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic [3:0] r,
    output logic [3:0] g,
    output logic [3:0] b
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [7:0] F_LAST   = 8'(FRAME_DIV - 1);

    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic [7:0] r_fcount;

    logic [PIPE_DELAY-1:0] r_hs_sr;
    logic [PIPE_DELAY-1:0] r_vs_sr;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_active;
    logic w_hs_raw;
    logic w_vs_raw;
    logic w_act_gate;

    assign w_h_wrap = (r_hcount == H_LAST);
    assign w_v_wrap = (r_vcount == V_LAST);
    assign w_active = (r_hcount < H_VIS) && (r_vcount < V_VIS);
    assign w_hs_raw = !((r_hcount >= HS_START) && (r_hcount < HS_END));
    assign w_vs_raw = !((r_vcount >= VS_START) && (r_vcount < VS_END));

    assign screenX = r_hcount;
    // Lines >= 512 alias here, but they are always blanked.
    assign screenY = r_vcount[8:0];
    assign active  = w_active;
    assign hsync   = r_hs_sr[PIPE_DELAY-1];
    assign vsync   = r_vs_sr[PIPE_DELAY-1];

    // Pixel / line / frame counters; frame counter steps on the joint wrap.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_fcount <= '0;
        end else if (w_h_wrap) begin
            r_hcount <= '0;
            if (w_v_wrap) begin
                r_vcount <= '0;
                if (r_fcount == F_LAST)
                    r_fcount <= '0;
                else
                    r_fcount <= r_fcount + 8'd1;
            end else begin
                r_vcount <= r_vcount + 10'd1;
            end
        end else begin
            r_hcount <= r_hcount + 10'd1;
        end
    end

    // Game tick: high through the vertical blanking of every FRAME_DIV-th frame.
    always_ff @(posedge vga_clock) begin
        if (reset)
            refresh <= 1'b0;
        else
            refresh <= (r_vcount >= V_VIS) && (r_fcount == 8'd0);
    end

    // Sync shift lines, idle high.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r_hs_sr <= '1;
            r_vs_sr <= '1;
        end else begin
            r_hs_sr[0] <= w_hs_raw;
            r_vs_sr[0] <= w_vs_raw;
            for (int i = 1; i < PIPE_DELAY; i++) begin
                r_hs_sr[i] <= r_hs_sr[i-1];
                r_vs_sr[i] <= r_vs_sr[i-1];
            end
        end
    end

    // Active delay line: PIPE_DELAY-1 stages here, the colour register is the last.
    generate
        if (PIPE_DELAY == 1) begin : g_act_direct
            assign w_act_gate = w_active;
        end else begin : g_act_line
            logic [PIPE_DELAY-2:0] r_act_sr;

            // Shift visibility toward the colour register, idle inactive.
            always_ff @(posedge vga_clock) begin
                if (reset) begin
                    r_act_sr <= '0;
                end else begin
                    r_act_sr[0] <= w_active;
                    for (int i = 1; i < PIPE_DELAY - 1; i++)
                        r_act_sr[i] <= r_act_sr[i-1];
                end
            end

            assign w_act_gate = r_act_sr[PIPE_DELAY-2];
        end
    endgenerate

    // Blanked colour register to the DAC pins.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            r <= '0;
            g <= '0;
            b <= '0;
        end else begin
            r <= w_act_gate ? r_in : 4'h0;
            g <= w_act_gate ? g_in : 4'h0;
            b <= w_act_gate ? b_in : 4'h0;
        end
    end

endmodule
